// File: rtl/multiport_register_file.sv
// Multi-port register file: NUM_READ combinational read ports, two write ports, optional
// write-to-read bypass and hardwired zero entry. A clear engine zeroes all entries after reset.
module multiport_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic [1:0]                     write_enable,
    input  logic [2*ADDR_WIDTH-1:0]        write_addr,
    input  logic [2*DATA_WIDTH-1:0]        write_data,
    output logic                           ready,
    output logic                           write_collision
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    ptr_t                  clear_ptr_q, clear_ptr_d;
    logic                  collision_q, collision_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr [2];
    logic [DATA_WIDTH-1:0] wr_data [2];
    logic [1:0]            wr_en;

    for (genvar w = 0; w < 2; w++) begin : g_wr
        assign wr_addr[w] = write_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_data[w] = write_data[w*DATA_WIDTH +: DATA_WIDTH];
        // Writes to the hardwired zero entry are dropped before they reach storage or bypass.
        assign wr_en[w]   = write_enable[w] && (state_q == StRun) &&
                            !(ZERO_REG && (wr_addr[w] == '0));
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        collision_d = wr_en[0] && wr_en[1] && (wr_addr[0] == wr_addr[1]);
        if (state_q == StInit) begin
            clear_ptr_d = clear_ptr_q + ptr_t'(1);
            if (clear_ptr_q == ptr_t'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StInit;
            clear_ptr_q <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            collision_q <= collision_d;
        end
    end

    // Port 1 is written last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == StInit) begin
                mem[clear_ptr_q[ADDR_WIDTH-1:0]] <= '0;
            end else begin
                if (wr_en[0]) mem[wr_addr[0]] <= wr_data[0];
                if (wr_en[1]) mem[wr_addr[1]] <= wr_data[1];
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem[ra];
            if (BYPASS) begin
                if (wr_en[0] && (wr_addr[0] == ra)) rd = wr_data[0];
                if (wr_en[1] && (wr_addr[1] == ra)) rd = wr_data[1];
            end
            if ((ZERO_REG && (ra == '0)) || (state_q != StRun)) begin
                rd = '0;
            end
        end

        assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

    assign ready           = (state_q == StRun);
    assign write_collision = collision_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: one bypassing and one non-bypassing instance driven with identical stimulus.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  read_addr;
    logic [1:0]  write_enable;
    logic [9:0]  write_addr;
    logic [63:0] write_data;
    logic [63:0] rdata_b1, rdata_b0;
    logic        ready_b1, ready_b0, coll_b1, coll_b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multiport_register_file #(.BYPASS(1'b1)) u_dut_byp (
        .clk             (clk),
        .reset_n         (reset_n),
        .read_addr       (read_addr),
        .read_data       (rdata_b1),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .ready           (ready_b1),
        .write_collision (coll_b1)
    );

    multiport_register_file #(.BYPASS(1'b0)) u_dut_nobyp (
        .clk             (clk),
        .reset_n         (reset_n),
        .read_addr       (read_addr),
        .read_data       (rdata_b0),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .ready           (ready_b0),
        .write_collision (coll_b0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_ready(input string tag, input logic exp);
        check_eq({tag, "_byp"},   {31'b0, ready_b1}, {31'b0, exp});
        check_eq({tag, "_nobyp"}, {31'b0, ready_b0}, {31'b0, exp});
    endtask

    initial begin
        reset_n      = 1'b0;
        read_addr    = '0;
        write_enable = '0;
        write_addr   = '0;
        write_data   = '0;
        tick(2);
        check_ready("ready_in_reset", 1'b0);

        // Release reset: 31 clear edges leave ready low, write in last INIT cycle is ignored.
        reset_n = 1'b1;
        tick(31);
        check_ready("ready_before_last_clear", 1'b0);
        write_enable    = 2'b01;
        write_addr[4:0] = 5'd3;
        write_data[31:0] = 32'hDEADBEEF;
        read_addr[4:0]  = 5'd3;
        #1;
        check_eq("init_read_forced_zero", rdata_b1[31:0], 32'h0);
        check_eq("init_collision", {31'b0, coll_b1}, 32'h0);
        tick(1);
        write_enable = '0;
        check_ready("ready_after_clear", 1'b1);

        // All entries cleared; port 1 scans in reverse.
        for (int a = 0; a < 32; a++) begin
            read_addr[4:0] = 5'(a);
            read_addr[9:5] = 5'(31 - a);
            #1;
            check_eq($sformatf("clear_p0_a%0d", a), rdata_b1[31:0], 32'h0);
            check_eq($sformatf("clear_p1_a%0d", 31 - a), rdata_b1[63:32], 32'h0);
            check_eq($sformatf("clear_nobyp_a%0d", a), rdata_b0[31:0], 32'h0);
        end

        // Port 0 write with same-cycle read.
        write_enable     = 2'b01;
        write_addr[4:0]  = 5'd8;
        write_data[31:0] = 32'hA5A5A5A5;
        read_addr[4:0]   = 5'd8;
        #1;
        check_eq("bypass_same_cycle", rdata_b1[31:0], 32'hA5A5A5A5);
        check_eq("nobypass_same_cycle", rdata_b0[31:0], 32'h0);
        tick(1);
        write_enable = '0;
        check_eq("bypass_next_cycle", rdata_b1[31:0], 32'hA5A5A5A5);
        check_eq("nobypass_next_cycle", rdata_b0[31:0], 32'hA5A5A5A5);

        // Both ports target the zero register: discarded, no collision.
        write_enable      = 2'b11;
        write_addr        = {5'd0, 5'd0};
        write_data        = {32'hFFFFFFFF, 32'h12345678};
        read_addr[4:0]    = 5'd0;
        #1;
        check_eq("zero_same_cycle", rdata_b1[31:0], 32'h0);
        tick(1);
        write_enable = '0;
        check_eq("zero_next_byp", rdata_b1[31:0], 32'h0);
        check_eq("zero_next_nobyp", rdata_b0[31:0], 32'h0);
        check_eq("zero_no_collision", {31'b0, coll_b1}, 32'h0);

        // Same-address double write: port 1 wins, one-cycle collision pulse.
        write_enable = 2'b11;
        write_addr   = {5'd9, 5'd9};
        write_data   = {32'h22222222, 32'h11111111};
        read_addr    = {5'd8, 5'd9};
        #1;
        check_eq("dual_bypass_prio", rdata_b1[31:0], 32'h22222222);
        check_eq("dual_nobypass_old", rdata_b0[31:0], 32'h0);
        check_eq("dual_port1_other", rdata_b1[63:32], 32'hA5A5A5A5);
        check_eq("collision_before_edge", {31'b0, coll_b1}, 32'h0);
        tick(1);
        write_enable = '0;
        check_eq("dual_stored_byp", rdata_b1[31:0], 32'h22222222);
        check_eq("dual_stored_nobyp", rdata_b0[31:0], 32'h22222222);
        check_eq("collision_pulse", {31'b0, coll_b1}, 32'h1);
        check_eq("collision_pulse_nobyp", {31'b0, coll_b0}, 32'h1);
        tick(1);
        check_eq("collision_cleared", {31'b0, coll_b1}, 32'h0);

        // Re-init, interrupted at clear_ptr = 10, then a full clear.
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_ready("ready_drop", 1'b0);
        tick(10);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        read_addr = {5'd9, 5'd8};
        #1;
        check_eq("reinit_forced_zero", rdata_b1[31:0], 32'h0);
        tick(31);
        check_ready("reinit_ready_low", 1'b0);
        tick(1);
        check_ready("reinit_ready_high", 1'b1);
        check_eq("reinit_addr8_byp", rdata_b1[31:0], 32'h0);
        check_eq("reinit_addr8_nobyp", rdata_b0[31:0], 32'h0);
        check_eq("reinit_addr9", rdata_b1[63:32], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
